// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries allocated at tail, completed out of order by
// writeback broadcasts, committed one per cycle from head; a mispredicted branch at head flushes all.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  // allocation
  input  logic             alloc_valid,
  input  logic [1:0]       alloc_type,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred_taken,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  // writeback broadcast
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_taken,
  input  logic [31:0]      wb_target,
  // operand lookup
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_value,
  output logic [31:0]      q2_value,
  // commit
  input  logic             reg_busy_commit_rd,
  input  logic [TAG_W-1:0] reg_reorder_commit_rd,
  output logic             commit_valid,
  output logic             commit_we,
  output logic             commit_clear_busy,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  // flush
  output logic             clear_flag,
  output logic [31:0]      redirect_pc
);

  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(ROB_SIZE);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [1:0]       TYPE_REG = 2'd0;
  localparam logic [1:0]       TYPE_BR  = 2'd1;

  // pointer / occupancy state
  logic [TAG_W-1:0]    head_q, head_d;
  logic [TAG_W-1:0]    tail_q, tail_d;
  logic [TAG_W:0]      count_q, count_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;

  // entry payload
  logic [1:0]  type_q   [ROB_SIZE];
  logic [4:0]  rd_q     [ROB_SIZE];
  logic [31:0] value_q  [ROB_SIZE];
  logic [31:0] pc_q     [ROB_SIZE];
  logic        pred_q   [ROB_SIZE];
  logic        taken_q  [ROB_SIZE];
  logic [31:0] target_q [ROB_SIZE];

  logic             alloc_fire;
  logic             wb_fire;
  logic             wb_live;
  logic [TAG_W-1:0] wb_off;
  logic             head_ready;
  logic             head_mispredict;

  // A writeback is only accepted for a slot between head and head+count.
  assign wb_off  = wb_tag - head_q;
  assign wb_live = ({1'b0, wb_off} < count_q);
  assign wb_fire = wb_valid && rdy && wb_live;

  assign alloc_ready = (count_q < CNT_FULL);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready && rdy && !clear_flag;

  // Commit sees only stored ready bits, so writeback-to-commit is at least one cycle.
  assign head_ready      = ready_q[head_q];
  assign head_mispredict = (type_q[head_q] == TYPE_BR) && (taken_q[head_q] != pred_q[head_q]);

  always_comb begin
    commit_valid      = (count_q != '0) && head_ready && rdy;
    commit_rd         = rd_q[head_q];
    commit_value      = value_q[head_q];
    commit_we         = commit_valid && (type_q[head_q] == TYPE_REG) && (rd_q[head_q] != 5'd0);
    commit_clear_busy = commit_we && reg_busy_commit_rd && (reg_reorder_commit_rd == head_q);
    clear_flag        = commit_valid && head_mispredict;
    redirect_pc       = 32'd0;
    if (clear_flag) begin
      redirect_pc = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
    end
  end

  // Operand lookup with same-cycle writeback bypass.
  always_comb begin
    q1_ready = ready_q[q1_tag];
    q1_value = value_q[q1_tag];
    q2_ready = ready_q[q2_tag];
    q2_value = value_q[q2_tag];
    if (wb_valid && (wb_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_value = wb_value;
    end
    if (wb_valid && (wb_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_value = wb_value;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ready_d = ready_q;
    if (clear_flag) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end else begin
      if (wb_fire) begin
        ready_d[wb_tag] = 1'b1;
      end
      if (alloc_fire) begin
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + TAG_ONE;
      end
      if (commit_valid) begin
        head_d = head_q + TAG_ONE;
      end
      case ({alloc_fire, commit_valid})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Payload needs no reset: every field is rewritten before its ready bit can be set.
  always_ff @(posedge clk) begin
    if (!rst && alloc_fire) begin
      type_q[tail_q] <= alloc_type;
      rd_q[tail_q]   <= alloc_rd;
      pc_q[tail_q]   <= alloc_pc;
      pred_q[tail_q] <= alloc_pred_taken;
    end
    if (!rst && wb_fire) begin
      value_q[wb_tag]  <= wb_value;
      taken_q[wb_tag]  <= wb_taken;
      target_q[wb_tag] <= wb_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer allocation, writeback, in-order
// commit, branch flush and reset, with a commit scoreboard.
module tb_reorder_buffer;
  localparam int ROB_SIZE = 16;
  localparam int TAG_W    = 4;

  logic             clk = 1'b0;
  logic             rst, rdy;
  logic             alloc_valid, alloc_pred_taken, alloc_ready;
  logic [1:0]       alloc_type;
  logic [4:0]       alloc_rd;
  logic [31:0]      alloc_pc;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid, wb_taken;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value, wb_target;
  logic [TAG_W-1:0] q1_tag, q2_tag;
  logic             q1_ready, q2_ready;
  logic [31:0]      q1_value, q2_value;
  logic             reg_busy_commit_rd;
  logic [TAG_W-1:0] reg_reorder_commit_rd;
  logic             commit_valid, commit_we, commit_clear_busy;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_value;
  logic             clear_flag;
  logic [31:0]      redirect_pc;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .reg_busy_commit_rd(reg_busy_commit_rd), .reg_reorder_commit_rd(reg_reorder_commit_rd),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_clear_busy(commit_clear_busy),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .clear_flag(clear_flag), .redirect_pc(redirect_pc)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] exp_q[$];                 // {we, rd, value} in allocation order
  logic [31:0] val_by_tag [ROB_SIZE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change right after the falling edge, checks run #1 later
  task automatic idle();
    alloc_valid = 1'b0; alloc_type = 2'd0; alloc_rd = 5'd0; alloc_pc = 32'd0;
    alloc_pred_taken = 1'b0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = 32'd0; wb_taken = 1'b0; wb_target = 32'd0;
    q1_tag = '0; q2_tag = '0;
    reg_busy_commit_rd = 1'b0; reg_reorder_commit_rd = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    exp_q.delete();
    cyc();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pred, input logic [31:0] val,
                       output logic ok, output logic [TAG_W-1:0] tag);
    alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred_taken = pred;
    #1;
    ok  = alloc_ready;
    tag = alloc_tag;
    if (ok && rdy) begin
      val_by_tag[tag] = val;
      exp_q.push_back({(t == 2'd0) && (rd != 5'd0), rd, val});
    end
    cyc();
  endtask

  task automatic drive_wb(input logic [TAG_W-1:0] tag, input logic [31:0] val,
                          input logic taken, input logic [31:0] target);
    wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_taken = taken; wb_target = target;
  endtask

  // scoreboard: called while commit_valid is high, before the committing edge
  task automatic sb_pop();
    logic [37:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("commit_we", 32'(commit_we), 32'(e[37]));
    check("commit_rd", 32'(commit_rd), 32'(e[36:32]));
    check("commit_value", commit_value, e[31:0]);
  endtask

  logic             ok;
  logic [TAG_W-1:0] tg;

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    @(negedge clk);

    // reset values
    do_reset();
    #1;
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_commit_we", 32'(commit_we), 32'd0);
    check("rst_clear_busy", 32'(commit_clear_busy), 32'd0);
    check("rst_clear_flag", 32'(clear_flag), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);

    // fill all 16 entries, tags in order, then a refused 17th
    for (int i = 0; i < ROB_SIZE; i++) begin
      alloc(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, $urandom, ok, tg);
      check("fill_ready", 32'(ok), 32'd1);
      check("fill_tag", 32'(tg), 32'(i));
    end
    #1;
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b1;
    cyc();
    #1;
    check("full_17th_tag", 32'(alloc_tag), 32'd0);
    check("full_17th_ready", 32'(alloc_ready), 32'd0);
    check("full_no_commit", 32'(commit_valid), 32'd0);

    // full buffer: commit with alloc_valid high must not allocate
    drive_wb(4'd0, val_by_tag[0], 1'b0, 32'd0);
    #1;
    check("wb_no_commit_bypass", 32'(commit_valid), 32'd0);
    cyc();
    alloc_valid = 1'b1;
    #1;
    check("full_commit_valid", 32'(commit_valid), 32'd1);
    check("full_commit_alloc_ready", 32'(alloc_ready), 32'd0);
    sb_pop();
    cyc();
    #1;
    check("after_commit_ready", 32'(alloc_ready), 32'd1);
    check("after_commit_tag", 32'(alloc_tag), 32'd0);
    alloc(2'd0, 5'd9, 32'h40, 1'b0, 32'h55, ok, tg);
    check("wrap_tag", 32'(tg), 32'd0);
    #1;
    check("wrap_next_tag", 32'(alloc_tag), 32'd1);
    check("wrap_full_again", 32'(alloc_ready), 32'd0);

    // single commit with rename-state match / mismatch, plus operand bypass
    do_reset();
    alloc(2'd0, 5'd5, 32'h1000, 1'b0, 32'h1234, ok, tg);
    drive_wb(4'd0, 32'h1234, 1'b0, 32'd0);
    q1_tag = 4'd0;
    q2_tag = 4'd1;
    #1;
    check("wb_cycle_commit_valid", 32'(commit_valid), 32'd0);
    check("q1_bypass_ready", 32'(q1_ready), 32'd1);
    check("q1_bypass_value", q1_value, 32'h1234);
    check("q2_not_ready", 32'(q2_ready), 32'd0);
    cyc();
    reg_busy_commit_rd = 1'b1;
    reg_reorder_commit_rd = 4'd0;
    q1_tag = 4'd0;
    #1;
    check("c1_valid", 32'(commit_valid), 32'd1);
    check("c1_we", 32'(commit_we), 32'd1);
    check("c1_rd", 32'(commit_rd), 32'd5);
    check("c1_value", commit_value, 32'h1234);
    check("c1_clear_busy", 32'(commit_clear_busy), 32'd1);
    check("q1_stored_ready", 32'(q1_ready), 32'd1);
    check("q1_stored_value", q1_value, 32'h1234);
    reg_reorder_commit_rd = 4'd3;
    #1;
    check("c1_clear_busy_other", 32'(commit_clear_busy), 32'd0);
    sb_pop();
    cyc();
    #1;
    check("c1_drained", 32'(commit_valid), 32'd0);
    // rd=0 never writes back; writeback to a free slot is dropped
    alloc(2'd0, 5'd0, 32'h1004, 1'b0, 32'h77, ok, tg);
    drive_wb(tg, 32'h77, 1'b0, 32'd0);
    cyc();
    drive_wb(4'd7, 32'hdead, 1'b0, 32'd0);
    #1;
    check("rd0_valid", 32'(commit_valid), 32'd1);
    check("rd0_we", 32'(commit_we), 32'd0);
    sb_pop();
    cyc();
    q1_tag = 4'd7;
    #1;
    check("free_wb_ignored", 32'(q1_ready), 32'd0);

    // out-of-order completion, in-order commit
    do_reset();
    for (int i = 0; i < 3; i++) alloc(2'd0, 5'($urandom_range(1, 31)), 32'(i), 1'b0, $urandom, ok, tg);
    drive_wb(4'd1, val_by_tag[1], 1'b0, 32'd0);
    #1;
    check("ooo_wait1", 32'(commit_valid), 32'd0);
    cyc();
    drive_wb(4'd2, val_by_tag[2], 1'b0, 32'd0);
    #1;
    check("ooo_wait2", 32'(commit_valid), 32'd0);
    cyc();
    drive_wb(4'd0, val_by_tag[0], 1'b0, 32'd0);
    #1;
    check("ooo_wait0", 32'(commit_valid), 32'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ooo_commit_valid", 32'(commit_valid), 32'd1);
      sb_pop();
      cyc();
    end
    #1;
    check("ooo_done", 32'(commit_valid), 32'd0);

    // mispredicted taken branch with younger entries; same-cycle alloc dropped
    do_reset();
    alloc(2'd1, 5'd0, 32'h100, 1'b0, 32'h0, ok, tg);
    alloc(2'd0, 5'd3, 32'h104, 1'b0, 32'h33, ok, tg);
    alloc(2'd0, 5'd4, 32'h108, 1'b0, 32'h44, ok, tg);
    drive_wb(4'd1, 32'h33, 1'b0, 32'd0);
    cyc();
    drive_wb(4'd0, 32'h0, 1'b1, 32'h200);
    cyc();
    alloc_valid = 1'b1;
    alloc_rd = 5'd8;
    #1;
    check("br_commit_valid", 32'(commit_valid), 32'd1);
    check("br_clear_flag", 32'(clear_flag), 32'd1);
    check("br_redirect_taken", redirect_pc, 32'h200);
    check("br_commit_we", 32'(commit_we), 32'd0);
    cyc();
    exp_q.delete();
    #1;
    check("flush_alloc_tag", 32'(alloc_tag), 32'd0);
    check("flush_alloc_ready", 32'(alloc_ready), 32'd1);
    check("flush_ready_cleared", 32'(commit_valid), 32'd0);
    // mispredicted not-taken: restart at pc+4
    alloc(2'd1, 5'd0, 32'h300, 1'b1, 32'h0, ok, tg);
    drive_wb(tg, 32'h0, 1'b0, 32'h999);
    cyc();
    #1;
    check("br_nt_clear_flag", 32'(clear_flag), 32'd1);
    check("br_nt_redirect", redirect_pc, 32'h304);
    cyc();
    exp_q.delete();
    // correctly predicted branch retires quietly
    alloc(2'd1, 5'd2, 32'h400, 1'b1, 32'h0, ok, tg);
    drive_wb(tg, 32'h0, 1'b1, 32'h500);
    cyc();
    #1;
    check("br_ok_valid", 32'(commit_valid), 32'd1);
    check("br_ok_clear_flag", 32'(clear_flag), 32'd0);
    check("br_ok_redirect", redirect_pc, 32'd0);
    sb_pop();
    cyc();

    // rdy low freezes; reset wins over rdy=0 with 8 live entries
    do_reset();
    for (int i = 0; i < 8; i++) alloc(2'd0, 5'd1, 32'(i), 1'b0, 32'(i), ok, tg);
    rdy = 1'b0;
    alloc_valid = 1'b1;
    drive_wb(4'd0, 32'h11, 1'b0, 32'd0);
    #1;
    check("frz_commit_valid", 32'(commit_valid), 32'd0);
    cyc();
    rdy = 1'b1;
    #1;
    check("frz_alloc_tag", 32'(alloc_tag), 32'd8);
    check("frz_wb_dropped", 32'(commit_valid), 32'd0);
    rdy = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rdy = 1'b1;
    exp_q.delete();
    #1;
    check("rst_live_alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst_live_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_live_alloc_ready", 32'(alloc_ready), 32'd1);
    cyc();

    // randomized rounds: random completion order drained through the scoreboard
    for (int r = 0; r < 4; r++) begin
      int n;
      int guard;
      int k;
      logic [1:0] t;
      logic [TAG_W-1:0] pend[$];
      pend.delete();
      n = $urandom_range(4, ROB_SIZE);
      for (int i = 0; i < n; i++) begin
        t = ($urandom_range(0, 2) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'd0;
        alloc(t, 5'($urandom_range(0, 31)), $urandom, 1'b0, $urandom, ok, tg);
        check("rand_alloc_ready", 32'(ok), 32'd1);
        pend.push_back(tg);
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
        if (pend.size() != 0) begin
          k = $urandom_range(0, pend.size() - 1);
          drive_wb(pend[k], val_by_tag[pend[k]], 1'b0, 32'd0);
          pend.delete(k);
        end
        #1;
        if (commit_valid) sb_pop();
        cyc();
        guard++;
      end
      check("rand_drain", 32'(exp_q.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
